// File: rtl/mod_counter_updown.sv
// Modulo-(FINAL_VALUE+1) up/down counter with synchronous clear, clamped parallel
// load, a combinational terminal count for cascading and a registered wrap pulse.
module mod_counter_updown #(
  parameter  int FINAL_VALUE = 9,
  localparam int WIDTH       = ($clog2(FINAL_VALUE + 1) < 1) ? 1 : $clog2(FINAL_VALUE + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(FINAL_VALUE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_top, at_bottom;

  assign at_top    = (q_q == MAX_Q);
  assign at_bottom = (q_q == '0);

  // tc deliberately ignores clear/load so a downstream stage can qualify it itself.
  assign tc = enable & ((up & at_top) | (~up & at_bottom));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    q_d    = q_q;
    wrap_d = tc & ~clear & ~load;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = (load_value > MAX_Q) ? MAX_Q : load_value;
    end else if (enable) begin
      if (up) begin
        q_d = at_top ? '0 : q_q + ONE;
      end else begin
        q_d = at_bottom ? MAX_Q : q_q - ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign wrap = wrap_q;

endmodule
